plic_gateway: RTL

Interrupt gateway between the raw device interrupt lines and the PLIC's `int_vect` input. It synchronises asynchronous sources and converts level or edge sources into single-cycle interrupt requests. After forwarding a request it holds each source off until the PLIC signals completion for that source ID, so a source never has more than one request in flight. Edge sources have a saturating counter so that edges arriving while a request is in flight are not lost.

---
 rtl/plic_gateway.sv | 120 ++++++++++++
 1 files changed

// File: rtl/plic_gateway.sv
// plic_gateway: turns raw asynchronous device interrupt lines into
// single-cycle PLIC requests. Each source is synchronised, then a small
// IDLE/INFLIGHT FSM forwards at most one request until the PLIC completes it.
// Edge-triggered sources buffer extra edges in a saturating counter.
module plic_gateway #(
    parameter int              ndev        = 8,
    parameter logic [ndev-1:0] edge_mask   = '0,
    parameter int              cwidth      = 4,
    parameter int              sync_stages = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ndev-1:0]         irq_src,
    input  logic                    cmpl_valid,
    input  logic [$clog2(ndev)-1:0] cmpl_id,
    output logic [ndev-1:0]         int_vect,
    output logic [ndev-1:0]         inflight
);

    localparam logic [cwidth-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_INFLIGHT = 1'b1
    } state_t;

    logic [ndev-1:0]   r_sync [sync_stages];
    logic [ndev-1:0]   r_prev;
    logic [ndev-1:0]   w_s;
    logic [ndev-1:0]   w_e;
    logic [ndev-1:0]   w_cmpl;
    logic [cwidth-1:0] r_cnt [ndev];
    state_t            r_state [ndev];
    logic [ndev-1:0]   r_int_vect;
    logic [ndev-1:0]   r_inflight;

    // Pending-edge counter stops at its maximum; further edges are dropped.
    function automatic logic [cwidth-1:0] sat_inc(input logic [cwidth-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Synchroniser chain plus previous-value flop; source 0 is forced low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < sync_stages; k++) begin
                r_sync[k] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq_src & ~ndev'(1);
            for (int k = 1; k < sync_stages; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= w_s;
        end
    end

    assign w_s = r_sync[sync_stages-1];
    assign w_e = w_s & ~r_prev;

    // Decode the completion strobe; id 0 and out-of-range ids match nothing.
    always_comb begin
        w_cmpl = '0;
        for (int i = 1; i < ndev; i++) begin
            w_cmpl[i] = cmpl_valid && (int'(cmpl_id) == i);
        end
    end

    // Per-source IDLE/INFLIGHT FSM with registered request pulse and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ndev; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_int_vect <= '0;
            r_inflight <= '0;
        end else begin
            r_int_vect <= '0;
            for (int i = 1; i < ndev; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (edge_mask[i]) begin
                            if ((r_cnt[i] != '0) || w_e[i]) begin
                                r_int_vect[i] <= 1'b1;
                                r_inflight[i] <= 1'b1;
                                r_state[i]    <= ST_INFLIGHT;
                                // A fresh edge is consumed directly; otherwise
                                // one buffered edge is taken from the counter.
                                if (!w_e[i]) begin
                                    r_cnt[i] <= r_cnt[i] - cwidth'(1);
                                end
                            end
                        end else if (w_s[i]) begin
                            r_int_vect[i] <= 1'b1;
                            r_inflight[i] <= 1'b1;
                            r_state[i]    <= ST_INFLIGHT;
                        end
                    end
                    ST_INFLIGHT: begin
                        if (w_cmpl[i]) begin
                            r_inflight[i] <= 1'b0;
                            r_state[i]    <= ST_IDLE;
                        end
                        // Edges seen while held off are remembered, including
                        // one that coincides with the completion.
                        if (edge_mask[i] && w_e[i]) begin
                            r_cnt[i] <= sat_inc(r_cnt[i]);
                        end
                    end
                    default: r_state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign int_vect = r_int_vect;
    assign inflight = r_inflight;

endmodule
